// File: rtl/l5q1d_pkg.sv
// Shared constants and a reference function for the l5q1d add/sub slice.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default operand width, add/sub mode encodings, addsub_ref() golden function.
package l5q1d_pkg;

  localparam int WIDTH_DEF = 3;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // Returns {carry/not-borrow, sum} at the default width.
  function automatic logic [WIDTH_DEF:0] addsub_ref(
    input logic [WIDTH_DEF-1:0] a,
    input logic [WIDTH_DEF-1:0] b,
    input logic                 c_in,
    input logic                 add
  );
    logic [WIDTH_DEF-1:0] b_sel;
    b_sel = (add == MODE_ADD) ? b : ~b;
    return {1'b0, a} + {1'b0, b_sel} + (WIDTH_DEF+1)'(c_in);
  endfunction

endpackage

// File: rtl/l5q1d_if.sv
// Operand/result bundle for the registered adder/subtractor.
// Latency: n/a (wires only). Backpressure: none, results stream every cycle.
// Ports: add, c_in, a, b driven by master; s, c_out (and ovf when L5Q1D_OVF_EN) driven by slave.
interface l5q1d_if #(
  parameter int WIDTH = 3
);
  logic             add;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef L5Q1D_OVF_EN
  logic             ovf;
`endif

`ifdef L5Q1D_OVF_EN
  modport master (output add, c_in, a, b, input s, c_out, ovf);
  modport slave  (input add, c_in, a, b, output s, c_out, ovf);
`else
  modport master (output add, c_in, a, b, input s, c_out);
  modport slave  (input add, c_in, a, b, output s, c_out);
`endif

endinterface

// File: rtl/l5q1d_full_adder.sv
// One-bit full adder cell, chained into a ripple adder by the top level.
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i, c_i inputs; s_o sum, c_o carry out.
module l5q1d_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/l5q1d_addsub.sv
// Registered WIDTH-bit two's-complement adder/subtractor with carry-in/carry-out.
// Latency: 1 cycle, new result every cycle. Backpressure: none (no enable, no handshake).
// Ports: clk, rst_n (async active-low), bus (l5q1d_if.slave: add, c_in, a, b -> s, c_out).
// Optional: define L5Q1D_OVF_EN to add registered signed-overflow output bus.ovf.
module l5q1d_addsub
  import l5q1d_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  l5q1d_if.slave  bus
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_out_d, c_out_q;

  // Subtract is a + ~b + c_in, so each b bit is inverted when not adding.
  assign b_x      = bus.b ^ {WIDTH{bus.add != MODE_ADD}};
  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    l5q1d_full_adder u_fa (
      .a_i (bus.a[i]),
      .b_i (b_x[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  always_comb begin
    s_d     = sum;
    c_out_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;

`ifdef L5Q1D_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_comb begin
    ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_l5q1d_addsub.sv
module tb_l5q1d_addsub;
  import l5q1d_pkg::*;

  localparam int W = 3;
  localparam int M = 1 << W;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  l5q1d_if #(.WIDTH(W)) bus ();

  l5q1d_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain integer arithmetic, unsigned and signed views.
  function automatic void model(input int add_m, input int a_m, input int b_m, input int cin_m,
                                output int s_m, output int c_m, output int o_m);
    int r, sa, sb, sr;
    sa = (a_m >= M/2) ? a_m - M : a_m;
    sb = (b_m >= M/2) ? b_m - M : b_m;
    if (add_m != 0) begin
      r   = a_m + b_m + cin_m;
      s_m = r % M;
      c_m = (r >= M) ? 1 : 0;
      sr  = sa + sb + cin_m;
    end else begin
      r   = a_m - b_m - (1 - cin_m);
      s_m = (r + M) % M;
      c_m = (r >= 0) ? 1 : 0;
      sr  = sa - sb - (1 - cin_m);
    end
    o_m = (sr < -(M/2) || sr >= M/2) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs, updated on the same edges as the DUT.
  int  exp_s = 0, exp_c = 0, exp_o = 0;
  bit  exp_valid = 0;

  always @(posedge clk) begin
    int ms, mc, mo;
    if (!rst_n) begin
      exp_s = 0; exp_c = 0; exp_o = 0;
    end else begin
      model(int'(bus.add), int'(bus.a), int'(bus.b), int'(bus.c_in), ms, mc, mo);
      exp_s = ms; exp_c = mc; exp_o = mo;
    end
    exp_valid = 1;
  end

  always @(negedge rst_n) begin
    exp_s = 0; exp_c = 0; exp_o = 0;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      check("cmp_s", int'(bus.s), exp_s);
      check("cmp_c_out", int'(bus.c_out), exp_c);
`ifdef L5Q1D_OVF_EN
      check("cmp_ovf", int'(bus.ovf), exp_o);
`endif
    end
  end

  task automatic drive(input logic ad, input int av, input int bv, input logic ci);
    bus.add  = ad;
    bus.a    = W'(av);
    bus.b    = W'(bv);
    bus.c_in = ci;
  endtask

  // Apply one vector on a falling edge and check the literal result after the next rising edge.
  task automatic vec(input string name, input logic ad, input int av, input int bv, input logic ci,
                     input int es, input int ec);
    @(negedge clk);
    drive(ad, av, bv, ci);
    @(posedge clk);
    #1;
    check({name, "_s"}, int'(bus.s), es);
    check({name, "_c"}, int'(bus.c_out), ec);
  endtask

  initial begin
    int ms, mc, mo;
    logic [W:0] ref_v;

    rst_n = 1'b0;
    drive(1'b1, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_s", int'(bus.s), 0);
    check("reset_c", int'(bus.c_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model and the package reference to hand-computed values.
    model(1, 7, 1, 0, ms, mc, mo);
    check("model_wrap_s", ms, 0);
    check("model_wrap_c", mc, 1);
    model(0, 3, 5, 1, ms, mc, mo);
    check("model_borrow_s", ms, 6);
    check("model_borrow_c", mc, 0);
    model(1, 3, 1, 0, ms, mc, mo);
    check("model_ovf_add", mo, 1);
    model(0, 4, 1, 1, ms, mc, mo);
    check("model_ovf_sub", mo, 1);
    ref_v = addsub_ref(3'd3, 3'd2, 1'b0, MODE_ADD);
    check("pkg_ref_add", int'(ref_v), 5);
    ref_v = addsub_ref(3'd3, 3'd5, 1'b1, MODE_SUB);
    check("pkg_ref_sub", int'(ref_v), 6);

    vec("add_nc",   1'b1, 3, 2, 1'b0, 5, 0);
    vec("add_ci",   1'b1, 3, 2, 1'b1, 6, 0);
    vec("add_wrap", 1'b1, 7, 1, 1'b0, 0, 1);
    vec("add_full", 1'b1, 7, 7, 1'b1, 7, 1);
    vec("sub_pos",  1'b0, 5, 3, 1'b1, 2, 1);
    vec("sub_brw",  1'b0, 3, 5, 1'b1, 6, 0);
    vec("sub_eq0",  1'b0, 4, 4, 1'b0, 7, 0);
    vec("tog_add",  1'b1, 1, 1, 1'b0, 2, 0);
    vec("tog_sub",  1'b0, 1, 1, 1'b1, 0, 1);

`ifdef L5Q1D_OVF_EN
    vec("ovf_add", 1'b1, 3, 1, 1'b0, 4, 0);
    check("ovf_add_o", int'(bus.ovf), 1);
    vec("ovf_sub", 1'b0, 4, 1, 1'b1, 3, 1);
    check("ovf_sub_o", int'(bus.ovf), 1);
`endif

    // Asynchronous reset mid-cycle with s = 5 held from the previous edge.
    vec("pre_rst", 1'b1, 3, 2, 1'b0, 5, 0);
    drive(1'b1, 7, 7, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_s", int'(bus.s), 0);
    check("arst_c", int'(bus.c_out), 0);
    @(posedge clk);
    #1;
    check("arst_hold_s", int'(bus.s), 0);
    check("arst_hold_c", int'(bus.c_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_s", int'(bus.s), 7);
    check("rel_c", int'(bus.c_out), 1);

    // Random soak; the compare process checks every cycle against the model.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, M-1)),
            int'($urandom_range(0, M-1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l5q1d_addsub.md
Name: l5q1d_addsub

Overview:
- Registered WIDTH-bit two's-complement adder/subtractor with carry-in and carry-out; mode selected per cycle by `add`.
- Drop-in equivalent of the core-generated adder/subtractor used in the lab datapath.
- Output is registered, giving one cycle of latency.
- Sits between operand registers and downstream display/compare logic.

Parameters:
- WIDTH, 3, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- add  input  1  mode: 1 = add, 0 = subtract
- c_in  input  1  carry-in (add) / not-borrow-in (subtract)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- s  output  WIDTH  registered sum/difference
- c_out  output  1  registered carry-out (add) / not-borrow-out (subtract)

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low forces s = 0 and c_out = 0 immediately, without waiting for clk. State is held while rst_n is low.
- Release of rst_n is synchronous in effect: the first capture happens on the first rising clk edge after rst_n goes high.
- Add mode (add=1): {c_out,s} <= a + b + c_in, computed in WIDTH+1 bits.
- Subtract mode (add=0): {c_out,s} <= a + ~b + c_in, computed in WIDTH+1 bits.
  - c_in=1 gives a-b.
  - c_in=0 gives a-b-1.
  - c_out=1 means no borrow (a >= b + !c_in, unsigned).
- Latency is exactly 1 cycle: inputs sampled at edge N appear on s/c_out after edge N. A new result is produced every cycle; there is no handshake and no enable.
- Wrap-around: s is the result modulo 2^WIDTH. The carry/borrow is reported only on c_out.
- `add` is sampled on the same edge as the operands; a mode change takes effect on that result only.
- Reset asserted mid-stream discards any in-flight result. No X propagation: all flops have defined reset values.

Optional Feature:
- Macro L5Q1D_OVF_EN.
- Defined:
  - Adds output `ovf` (1 bit), registered alongside s and reset to 0.
  - `ovf` = signed two's-complement overflow of the selected operation: carry into MSB XOR carry out of MSB, using ~b in subtract mode.
- Undefined: the `ovf` port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package l5q1d_pkg holds:
  - WIDTH default constant.
  - Mode constants MODE_ADD=1'b1 and MODE_SUB=1'b0.
  - Function `addsub_ref(a,b,c_in,add)` returning WIDTH+1 bits, for reuse by the bench scoreboard.
- One natural sub-module: l5q1d_full_adder, a 1-bit sum/carry cell.
  - Instantiated WIDTH times via generate as a ripple chain.
  - The b input to each cell is XORed with ~add.
- Top level holds the output registers and, under the macro, the overflow term.

Test Plan (WIDTH=3):
1. Reset: assert rst_n=0 mid-cycle with s previously 3'b101 -> s=0 and c_out=0 immediately, before the next edge; they stay 0 until the first edge after release.
2. Add without carry: add=1, a=3, b=2, c_in=0 -> one edge later s=5, c_out=0. Same operands with c_in=1 -> s=6, c_out=0.
3. Add wrap: add=1, a=7, b=1, c_in=0 -> s=0, c_out=1. With a=7, b=7, c_in=1 -> s=7, c_out=1.
4. Subtract: add=0, a=5, b=3, c_in=1 -> s=2, c_out=1. With a=3, b=5, c_in=1 -> s=6, c_out=0 (borrow). With a=4, b=4, c_in=0 -> s=7, c_out=0.
5. Back-to-back mode toggle:
   - Stimulus: edge1 add=1 a=1 b=1 c_in=0; edge2 add=0 a=1 b=1 c_in=1.
   - Response: s=2 after edge1 and s=0, c_out=1 after edge2, confirming 1-cycle latency and per-cycle mode.
6. Random soak: 50+ cycles of random a, b, c_in, add at 10 ns per vector -> every output matches `addsub_ref` of the previous cycle's inputs. With L5Q1D_OVF_EN: add a=3, b=1 -> ovf=1; sub a=4, b=1, c_in=1 -> ovf=1.
